// File: rtl/instr_seq_branch_unit.sv
// ---------------------------------------------------------------------------
// instr_seq_branch_unit
//
// Instruction sequencer / branch unit for the 32-bit-IR CPU.
// Fetches instructions from a synchronous instruction memory (one-cycle read
// latency), decodes the 5-bit opcode in IR[31:27], and either:
//   * forwards ALU/logic instructions (00000-01011) to the execute datapath
//     over a valid/ready handshake, then waits for exec_done and latches the
//     returned condition flags;
//   * resolves conditional/unconditional jumps locally from the latched flags;
//   * treats 10110-11111 as nop;
//   * stops in HALT on the halt opcode until a new start pulse.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 single-cycle pulse, starts from IDLE or HALT
//   imem_en/imem_addr     instruction memory read request
//   imem_rdata            read data, valid one cycle after imem_en
//   ir_out/ir_valid       instruction offered to the datapath
//   ir_ready              datapath accepts ir_out when ir_valid & ir_ready
//   exec_done, flag_*_in  datapath completion and its condition flags
//   pc                    current program counter
//   flags                 latched {sign, zero, overflow, carry}
//   busy                  high in every state except IDLE and HALT
//   halted                high in HALT
//
// Every output comes straight from a flop; the output flops are loaded from
// the next-state decision so they line up with the state they describe.
// ---------------------------------------------------------------------------
module instr_seq_branch_unit #(
  parameter int          ADDR_W   = 11,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              exec_done,
  input  logic              flag_sign_in,
  input  logic              flag_zero_in,
  input  logic              flag_overflow_in,
  input  logic              flag_carry_in,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  // Opcode map for the operations resolved inside this block.
  localparam logic [4:0] OP_LAST_ALU = 5'b01011;
  localparam logic [4:0] OP_JMP      = 5'b01100;
  localparam logic [4:0] OP_JC       = 5'b01101;
  localparam logic [4:0] OP_JNC      = 5'b01110;
  localparam logic [4:0] OP_JS       = 5'b01111;
  localparam logic [4:0] OP_JNS      = 5'b10000;
  localparam logic [4:0] OP_JZ       = 5'b10001;
  localparam logic [4:0] OP_JNZ      = 5'b10010;
  localparam logic [4:0] OP_JO       = 5'b10011;
  localparam logic [4:0] OP_JNO      = 5'b10100;
  localparam logic [4:0] OP_HALT     = 5'b10101;

  // Bit positions inside the latched flag vector {sign, zero, overflow, carry}.
  localparam int F_SIGN  = 3;
  localparam int F_ZERO  = 2;
  localparam int F_OVF   = 1;
  localparam int F_CARRY = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_MEMWAIT  = 3'd2,
    S_DECODE   = 3'd3,
    S_ISSUE    = 3'd4,
    S_WAITEXEC = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              imem_en_q, imem_en_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;
  logic              is_jump;
  logic              jump_taken;

  assign opcode      = ir_q[31:27];
  // Natural ADDR_W-bit arithmetic gives the modulo-2^ADDR_W wrap.
  assign pc_inc      = pc_q + ADDR_W'(1);
  // Target bits above ADDR_W are simply dropped.
  assign jump_target = ir_q[ADDR_W-1:0];
  assign is_jump     = (opcode >= OP_JMP) && (opcode <= OP_JNO);

  // Branch condition evaluated against the flags of the last completed
  // datapath instruction.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = flags_q[F_CARRY];
      OP_JNC:  jump_taken = ~flags_q[F_CARRY];
      OP_JS:   jump_taken = flags_q[F_SIGN];
      OP_JNS:  jump_taken = ~flags_q[F_SIGN];
      OP_JZ:   jump_taken = flags_q[F_ZERO];
      OP_JNZ:  jump_taken = ~flags_q[F_ZERO];
      OP_JO:   jump_taken = flags_q[F_OVF];
      OP_JNO:  jump_taken = ~flags_q[F_OVF];
      default: jump_taken = 1'b0;
    endcase
  end

  // Next-state and next-register computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    ir_d    = ir_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC_A;
          flags_d = 4'b0000;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_MEMWAIT;
      end

      S_MEMWAIT: begin
        // Memory data for the address presented in FETCH is valid now.
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (opcode <= OP_LAST_ALU) begin
          state_d = S_ISSUE;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (is_jump) begin
          pc_d    = jump_taken ? jump_target : pc_inc;
          state_d = S_FETCH;
        end else begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      S_ISSUE: begin
        if (ir_ready) begin
          state_d = S_WAITEXEC;
        end
      end

      S_WAITEXEC: begin
        if (exec_done) begin
          flags_d = {flag_sign_in, flag_zero_in, flag_overflow_in, flag_carry_in};
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC_A;
          flags_d = 4'b0000;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops are loaded from the state being entered, so each output
    // is valid for exactly the cycles spent in the matching state.
    imem_en_d  = (state_d == S_FETCH);
    ir_valid_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC_A;
      flags_q    <= 4'b0000;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      imem_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      imem_en_q  <= imem_en_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_seq_branch_unit.sv
// ---------------------------------------------------------------------------
// Testbench for instr_seq_branch_unit (ADDR_W = 6, 64-word program memory).
// An instruction-level reference model (program counter + flag register,
// advanced one architectural instruction at a time) predicts every fetch
// address, issued instruction, PC and flag value. A directed program covers
// the named scenarios, then random programs exercise the model further.
// ---------------------------------------------------------------------------
module tb_instr_seq_branch_unit;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  localparam logic [31:0] I_MOV  = 32'h0841_0005;
  localparam logic [31:0] I_JMP  = 32'h6000_0000;
  localparam logic [31:0] I_JZ   = 32'h8800_0000;
  localparam logic [31:0] I_HALT = 32'hA800_0000;
  localparam logic [31:0] I_NOP  = 32'hB000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   ir_out;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic          exec_done = 1'b0;
  logic          flag_sign_in = 1'b0;
  logic          flag_zero_in = 1'b0;
  logic          flag_overflow_in = 1'b0;
  logic          flag_carry_in = 1'b0;
  logic [AW-1:0] pc;
  logic [3:0]    flags;
  logic          busy;
  logic          halted;

  logic [31:0]   imem [DEPTH];

  int            n_checks = 0;
  int            n_pass = 0;
  int            n_fail = 0;

  // Reference model state: architectural PC and flags {sign,zero,ovf,carry}.
  int            m_pc = 0;
  logic [3:0]    m_flags = 4'b0000;

  instr_seq_branch_unit #(
    .ADDR_W   (AW),
    .RESET_PC (0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .imem_en          (imem_en),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .ir_out           (ir_out),
    .ir_valid         (ir_valid),
    .ir_ready         (ir_ready),
    .exec_done        (exec_done),
    .flag_sign_in     (flag_sign_in),
    .flag_zero_in     (flag_zero_in),
    .flag_overflow_in (flag_overflow_in),
    .flag_carry_in    (flag_carry_in),
    .pc               (pc),
    .flags            (flags),
    .busy             (busy),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags_in(input logic [3:0] f);
    {flag_sign_in, flag_zero_in, flag_overflow_in, flag_carry_in} = f;
  endtask

  // Architectural branch rule: jmp always; jc/jnc carry, js/jns sign,
  // jz/jnz zero, jo/jno overflow.
  function automatic bit branch_taken(input int op, input logic [3:0] f);
    case (op)
      12: return 1'b1;
      13: return f[0] == 1'b1;
      14: return f[0] == 1'b0;
      15: return f[3] == 1'b1;
      16: return f[3] == 1'b0;
      17: return f[2] == 1'b1;
      18: return f[2] == 1'b0;
      19: return f[1] == 1'b1;
      20: return f[1] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int r;
    int op;
    r = int'($urandom_range(0, 99));
    if (r < 40)      op = int'($urandom_range(0, 11));
    else if (r < 85) op = int'($urandom_range(12, 20));
    else if (r < 95) op = int'($urandom_range(22, 31));
    else             op = 21;
    return {5'(op), 27'($urandom)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"},       32'(pc), 32'd0);
    chk({tag, "_flags"},    32'(flags), 32'd0);
    chk({tag, "_ir_out"},   ir_out, 32'd0);
    chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, "_imem_en"},  32'(imem_en), 32'd0);
    chk({tag, "_halted"},   32'(halted), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  // Execute one architectural instruction. Entry and exit: observation point
  // of a FETCH cycle. bp < 0 selects a random backpressure length.
  task automatic run_one(input int bp, input bit force_f, input logic [3:0] fval);
    logic [31:0] ins;
    int          op;
    int          nwait;
    logic [3:0]  nf;

    chk("fetch_en",    32'(imem_en), 32'd1);
    chk("fetch_addr",  32'(imem_addr), 32'(m_pc));
    chk("fetch_pc",    32'(pc), 32'(m_pc));
    chk("fetch_flags", 32'(flags), 32'(m_flags));
    ins = imem[m_pc];
    op  = int'(ins[31:27]);

    // Noise during FETCH and MEMWAIT that must be ignored.
    exec_done = 1'($urandom);
    start     = 1'($urandom);
    ir_ready  = 1'($urandom);
    set_flags_in(4'($urandom));
    tick();
    chk("memwait_en",   32'(imem_en), 32'd0);
    chk("memwait_busy", 32'(busy), 32'd1);
    exec_done = 1'($urandom);
    start     = 1'($urandom);
    ir_ready  = 1'($urandom);
    tick();
    exec_done = 1'b0;
    start     = 1'b0;
    ir_ready  = 1'b0;
    tick();

    if (op <= 11) begin
      chk("issue_valid", 32'(ir_valid), 32'd1);
      chk("issue_ir",    ir_out, ins);
      nwait = (bp >= 0) ? bp : int'($urandom_range(0, 3));
      for (int k = 0; k < nwait; k++) begin
        ir_ready  = 1'b0;
        exec_done = 1'($urandom);
        set_flags_in(4'($urandom));
        tick();
        chk("bp_valid", 32'(ir_valid), 32'd1);
        chk("bp_ir",    ir_out, ins);
        chk("bp_flags", 32'(flags), 32'(m_flags));
      end
      exec_done = 1'b0;
      ir_ready  = 1'b1;
      tick();
      ir_ready = 1'($urandom);
      chk("valid_drop", 32'(ir_valid), 32'd0);
      nwait = int'($urandom_range(0, 2));
      for (int k = 0; k < nwait; k++) begin
        start = 1'($urandom);
        tick();
        chk("wait_en",    32'(imem_en), 32'd0);
        chk("wait_flags", 32'(flags), 32'(m_flags));
      end
      start = 1'b0;
      nf = force_f ? fval : 4'($urandom);
      set_flags_in(nf);
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      ir_ready  = 1'b0;
      m_flags = nf;
      m_pc    = (m_pc + 1) % DEPTH;
    end else if (op == 21) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy",   32'(busy), 32'd0);
      chk("halt_pc",     32'(pc), 32'(m_pc));
      for (int k = 0; k < 3; k++) begin
        exec_done = 1'($urandom);
        ir_ready  = 1'($urandom);
        set_flags_in(4'($urandom));
        tick();
        chk("halt_en",     32'(imem_en), 32'd0);
        chk("halt_valid",  32'(ir_valid), 32'd0);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_pc2",    32'(pc), 32'(m_pc));
        chk("halt_flags",  32'(flags), 32'(m_flags));
      end
      exec_done = 1'b0;
      ir_ready  = 1'b0;
      start     = 1'b1;
      tick();
      start   = 1'b0;
      m_pc    = 0;
      m_flags = 4'b0000;
    end else begin
      chk("nonissue_valid", 32'(ir_valid), 32'd0);
      if (branch_taken(op, m_flags)) m_pc = int'(ins[AW-1:0]);
      else                           m_pc = (m_pc + 1) % DEPTH;
    end
    $display("txn ins=%08h op=%0d next_pc=%0d flags=%b", ins, op, m_pc, m_flags);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = I_NOP;

    // Reset values, then IDLE ignores exec_done.
    #3;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    exec_done = 1'b1;
    set_flags_in(4'hF);
    tick();
    exec_done = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Directed program.
    imem[0]  = I_MOV;
    imem[1]  = I_JZ | 32'h020;
    imem[32] = 32'h0000_1234;
    imem[33] = I_JZ | 32'h005;
    imem[34] = I_JMP | 32'h7F3;
    imem[51] = I_JMP | 32'd63;
    imem[63] = I_NOP;
    m_pc    = 0;
    m_flags = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;

    run_one(6, 1'b1, 4'b0100);            // mov, 6 cycles backpressure, zero=1
    chk("mov_pc", 32'(pc), 32'd1);
    chk("mov_flags", 32'(flags), 32'h4);
    run_one(0, 1'b0, 4'b0000);            // jz taken
    chk("jz_taken_pc", 32'(pc), 32'd32);
    run_one(0, 1'b1, 4'b0000);            // ALU, zero=0
    run_one(0, 1'b0, 4'b0000);            // jz not taken
    chk("jz_nt_pc", 32'(pc), 32'd34);
    imem[0] = I_JMP | 32'd7;
    imem[7] = I_HALT;
    run_one(0, 1'b0, 4'b0000);            // jmp 0x7F3 -> 51
    chk("jmp_trunc_pc", 32'(pc), 32'd51);
    run_one(0, 1'b0, 4'b0000);            // jmp 63
    run_one(0, 1'b0, 4'b0000);            // nop at 63 wraps
    chk("wrap_pc", 32'(pc), 32'd0);
    run_one(0, 1'b0, 4'b0000);            // jmp 7
    run_one(0, 1'b0, 4'b0000);            // halt at 7, restart
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_flags", 32'(flags), 32'd0);

    // Random programs against the reference model.
    for (int i = 0; i < DEPTH; i++) imem[i] = rand_instr();
    for (int n = 0; n < 300; n++) run_one(-1, 1'b0, 4'b0000);

    // Asynchronous reset while waiting for the datapath.
    imem[m_pc] = 32'h1000_0042;
    tick();
    tick();
    tick();
    chk("ar_issue", 32'(ir_valid), 32'd1);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("ar_waitexec_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    exec_done = 1'b1;
    set_flags_in(4'hF);
    tick();
    rst_n = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();
    check_reset_outputs("post_areset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
